// File: rtl/retire_unit_pkg.sv
// rtl/retire_unit_pkg.sv - shared ROB sizing constants, entry type and free-tag helper
package retire_unit_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int DEPTH      = ROB_DEPTH;
  localparam int PREG_WIDTH = 6;
  localparam int AREG_WIDTH = 5;
  localparam int IDX_WIDTH  = $clog2(DEPTH);

  typedef struct packed {
    logic                  reg_write;
    logic [AREG_WIDTH-1:0] areg;
    logic [PREG_WIDTH-1:0] preg;
    logic [PREG_WIDTH-1:0] old_preg;
  } rob_entry_t;

  // x0 is never remapped, so its freshly allocated tag is the one to recycle.
  function automatic logic [PREG_WIDTH-1:0] free_tag(input rob_entry_t e);
    return (e.areg == '0) ? e.preg : e.old_preg;
  endfunction

endpackage

// File: rtl/retire_unit_if.sv
// rtl/retire_unit_if.sv - rename/complete/retire handshake bundle for the retire unit
interface retire_unit_if;
  import retire_unit_pkg::*;

  logic                  alloc_valid;
  logic                  alloc_ready;
  logic                  alloc_reg_write;
  logic [AREG_WIDTH-1:0] alloc_areg;
  logic [PREG_WIDTH-1:0] alloc_preg;
  logic [PREG_WIDTH-1:0] alloc_old_preg;
  logic [IDX_WIDTH-1:0]  alloc_idx;
  logic                  cmpl_valid;
  logic [IDX_WIDTH-1:0]  cmpl_idx;
  logic                  retire_en;
  logic                  retire_valid;
  logic [AREG_WIDTH-1:0] retire_areg;
  logic [PREG_WIDTH-1:0] retire_preg;
  logic                  push_free_reg;
  logic [PREG_WIDTH-1:0] freed_reg;
  logic [IDX_WIDTH:0]    count;
  logic                  empty;
  logic                  full;

  modport master (
    output alloc_valid, alloc_reg_write, alloc_areg, alloc_preg, alloc_old_preg,
    output cmpl_valid, cmpl_idx, retire_en,
    input  alloc_ready, alloc_idx, retire_valid, retire_areg, retire_preg,
    input  push_free_reg, freed_reg, count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_reg_write, alloc_areg, alloc_preg, alloc_old_preg,
    input  cmpl_valid, cmpl_idx, retire_en,
    output alloc_ready, alloc_idx, retire_valid, retire_areg, retire_preg,
    output push_free_reg, freed_reg, count, empty, full
  );

endinterface

// File: rtl/retire_unit.sv
// rtl/retire_unit.sv - in-order retirement buffer returning displaced tags to the free pool
module retire_unit
  import retire_unit_pkg::*;
(
  input logic          clk,
  input logic          rst,
  retire_unit_if.slave bus
);

  localparam logic [IDX_WIDTH:0] FULL_COUNT = (IDX_WIDTH+1)'(DEPTH);

  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_done;
  rob_entry_t            r_entry [DEPTH];
  logic [IDX_WIDTH-1:0]  r_head;
  logic [IDX_WIDTH-1:0]  r_tail;
  logic [IDX_WIDTH:0]    r_count;

  logic                  r_retire_valid;
  logic [AREG_WIDTH-1:0] r_retire_areg;
  logic [PREG_WIDTH-1:0] r_retire_preg;
  logic                  r_push_free_reg;
  logic [PREG_WIDTH-1:0] r_freed_reg;

  logic                  w_full;
  logic                  w_alloc_fire;
  logic                  w_retire_fire;
  rob_entry_t            w_alloc_entry;
  rob_entry_t            w_head_entry;
  logic [IDX_WIDTH:0]    w_alloc_inc;
  logic [IDX_WIDTH:0]    w_retire_dec;

  assign w_full        = (r_count == FULL_COUNT);
  assign w_alloc_fire  = bus.alloc_valid && !w_full;
  assign w_retire_fire = bus.retire_en && r_valid[r_head] && r_done[r_head];
  assign w_head_entry  = r_entry[r_head];
  assign w_alloc_inc   = {{IDX_WIDTH{1'b0}}, w_alloc_fire};
  assign w_retire_dec  = {{IDX_WIDTH{1'b0}}, w_retire_fire};

  assign w_alloc_entry.reg_write = bus.alloc_reg_write;
  assign w_alloc_entry.areg      = bus.alloc_areg;
  assign w_alloc_entry.preg      = bus.alloc_preg;
  assign w_alloc_entry.old_preg  = bus.alloc_old_preg;

  // Payload needs no reset: an entry is only ever read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (rst && w_alloc_fire) begin
      r_entry[r_tail] <= w_alloc_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid         <= '0;
      r_done          <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_retire_valid  <= 1'b0;
      r_retire_areg   <= '0;
      r_retire_preg   <= '0;
      r_push_free_reg <= 1'b0;
      r_freed_reg     <= '0;
    end else begin
      if (w_alloc_fire) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + IDX_WIDTH'(1);
      end
      if (bus.cmpl_valid && r_valid[bus.cmpl_idx]) begin
        r_done[bus.cmpl_idx] <= 1'b1;
      end
      // Placed after the completion update so clearing the retiring head wins.
      if (w_retire_fire) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + IDX_WIDTH'(1);
      end
      r_count <= r_count + w_alloc_inc - w_retire_dec;

      r_retire_valid  <= w_retire_fire;
      r_retire_areg   <= w_retire_fire ? w_head_entry.areg : '0;
      r_retire_preg   <= w_retire_fire ? w_head_entry.preg : '0;
      r_push_free_reg <= w_retire_fire && w_head_entry.reg_write;
      r_freed_reg     <= (w_retire_fire && w_head_entry.reg_write) ?
                         free_tag(w_head_entry) : '0;
    end
  end

  assign bus.alloc_ready   = !w_full;
  assign bus.alloc_idx     = r_tail;
  assign bus.count         = r_count;
  assign bus.empty         = (r_count == '0);
  assign bus.full          = w_full;
  assign bus.retire_valid  = r_retire_valid;
  assign bus.retire_areg   = r_retire_areg;
  assign bus.retire_preg   = r_retire_preg;
  assign bus.push_free_reg = r_push_free_reg;
  assign bus.freed_reg     = r_freed_reg;

endmodule

// File: tb/tb_retire_unit.sv
// tb/tb_retire_unit.sv - directed and random checks of retire_unit against a queue model
module tb_retire_unit;
  import retire_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  retire_unit_if bus();

  retire_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit rw;
    int areg;
    int preg;
    int old;
    bit done;
  } ment_t;

  ment_t q[$];
  int    m_tail  = 0;
  bit    m_known = 1'b0;
  int    vectors = 0;
  int    errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: check occupancy outputs, advance the model, then check retire outputs.
  task automatic cycle();
    bit    ret_fire;
    bit    al_fire;
    ment_t e;
    int    x_rv = 0, x_ar = 0, x_pr = 0, x_pu = 0, x_fr = 0;
    if (m_known) begin
      chk("count",       32'(bus.count),       q.size());
      chk("empty",       32'(bus.empty),       (q.size() == 0) ? 1 : 0);
      chk("full",        32'(bus.full),        (q.size() == DEPTH) ? 1 : 0);
      chk("alloc_ready", 32'(bus.alloc_ready), (q.size() < DEPTH) ? 1 : 0);
      chk("alloc_idx",   32'(bus.alloc_idx),   m_tail);
    end
    if (!rst) begin
      q.delete();
      m_tail  = 0;
      m_known = 1'b1;
    end else begin
      ret_fire = bus.retire_en && (q.size() > 0) && q[0].done;
      al_fire  = bus.alloc_valid && (q.size() < DEPTH);
      if (bus.cmpl_valid) begin
        foreach (q[i]) if (q[i].idx == int'(bus.cmpl_idx)) q[i].done = 1'b1;
      end
      if (ret_fire) begin
        e = q.pop_front();
        x_rv = 1;
        x_ar = e.areg;
        x_pr = e.preg;
        x_pu = e.rw ? 1 : 0;
        x_fr = e.rw ? ((e.areg == 0) ? e.preg : e.old) : 0;
      end
      if (al_fire) begin
        e.idx  = m_tail;
        e.rw   = bus.alloc_reg_write;
        e.areg = int'(bus.alloc_areg);
        e.preg = int'(bus.alloc_preg);
        e.old  = int'(bus.alloc_old_preg);
        e.done = 1'b0;
        q.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(posedge clk);
    #1;
    chk("retire_valid",  32'(bus.retire_valid),  x_rv);
    chk("retire_areg",   32'(bus.retire_areg),   x_ar);
    chk("retire_preg",   32'(bus.retire_preg),   x_pr);
    chk("push_free_reg", 32'(bus.push_free_reg), x_pu);
    chk("freed_reg",     32'(bus.freed_reg),     x_fr);
  endtask

  task automatic drive_alloc(input bit v, input bit rw, input int areg, input int preg, input int old);
    bus.alloc_valid     = v;
    bus.alloc_reg_write = rw;
    bus.alloc_areg      = AREG_WIDTH'(areg);
    bus.alloc_preg      = PREG_WIDTH'(preg);
    bus.alloc_old_preg  = PREG_WIDTH'(old);
  endtask

  task automatic drive_cmpl(input bit v, input int idx);
    bus.cmpl_valid = v;
    bus.cmpl_idx   = IDX_WIDTH'(idx);
  endtask

  task automatic random_traffic(input int n, input int reset_pct);
    for (int i = 0; i < n; i++) begin
      rst = ($urandom_range(99, 0) < reset_pct) ? 1'b0 : 1'b1;
      drive_alloc(($urandom % 3) != 0, ($urandom % 4) != 0, int'($urandom % 32),
                  int'($urandom % 64), int'($urandom % 64));
      if (q.size() > 0 && ($urandom % 4) != 0)
        drive_cmpl($urandom % 2, q[$urandom_range(q.size() - 1, 0)].idx);
      else
        drive_cmpl($urandom % 2, int'($urandom % DEPTH));
      bus.retire_en = ($urandom % 4) != 0;
      cycle();
    end
    rst = 1'b1;
  endtask

  initial begin
    int k;
    drive_alloc(0, 0, 0, 0, 0);
    drive_cmpl(0, 0);
    bus.retire_en = 1'b0;

    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    random_traffic(30, 0);

    // Reset after traffic
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    drive_alloc(0, 0, 0, 0, 0);
    drive_cmpl(0, 0);
    bus.retire_en = 1'b0;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_alloc_idx", 32'(bus.alloc_idx), 0);
    chk("rst_push", 32'(bus.push_free_reg), 0);

    // In-order retire with out-of-order completion
    drive_alloc(1, 1, 3, 40, 3);
    cycle();
    drive_alloc(1, 1, 5, 41, 5);
    cycle();
    drive_alloc(0, 0, 0, 0, 0);
    bus.retire_en = 1'b1;
    drive_cmpl(1, 1);
    cycle();
    chk("inorder_wait1", 32'(bus.retire_valid), 0);
    drive_cmpl(1, 0);
    cycle();
    chk("inorder_wait0", 32'(bus.retire_valid), 0);
    drive_cmpl(0, 0);
    cycle();
    chk("inorder_free3", 32'(bus.freed_reg), 3);
    chk("inorder_push3", 32'(bus.push_free_reg), 1);
    cycle();
    chk("inorder_free5", 32'(bus.freed_reg), 5);
    chk("inorder_push5", 32'(bus.push_free_reg), 1);

    // x0 recycles its fresh tag; non-writing entries push nothing
    k = m_tail;
    drive_alloc(1, 1, 0, 42, 0);
    cycle();
    drive_alloc(0, 0, 0, 0, 0);
    drive_cmpl(1, k);
    cycle();
    drive_cmpl(0, 0);
    cycle();
    chk("x0_freed", 32'(bus.freed_reg), 42);
    k = m_tail;
    drive_alloc(1, 0, 7, 20, 9);
    cycle();
    drive_alloc(0, 0, 0, 0, 0);
    drive_cmpl(1, k);
    cycle();
    drive_cmpl(0, 0);
    cycle();
    chk("nowr_valid", 32'(bus.retire_valid), 1);
    chk("nowr_push", 32'(bus.push_free_reg), 0);

    // Fill, overflow attempt, drain, wrap
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    bus.retire_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_alloc(1, 1, 1 + i, 10 + i, 30 + i);
      cycle();
    end
    chk("full_flag", 32'(bus.full), 1);
    chk("full_ready", 32'(bus.alloc_ready), 0);
    drive_alloc(1, 1, 9, 63, 62);
    cycle();
    chk("full_ignored", 32'(bus.count), DEPTH);
    drive_alloc(0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      drive_cmpl(1, i);
      cycle();
    end
    drive_cmpl(0, 0);
    bus.retire_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      chk("drain_freed", 32'(bus.freed_reg), 30 + i);
    end
    bus.retire_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wrap_idx", 32'(bus.alloc_idx), i);
      drive_alloc(1, 1, 4 + i, 50 + i, 20 + i);
      cycle();
    end

    // Simultaneous alloc and retire at count=5
    for (int i = 0; i < 2; i++) begin
      drive_alloc(1, 1, 8 + i, 55 + i, 25 + i);
      cycle();
    end
    drive_alloc(0, 0, 0, 0, 0);
    drive_cmpl(1, 0);
    cycle();
    drive_cmpl(0, 0);
    chk("sim_count_pre", 32'(bus.count), 5);
    drive_alloc(1, 1, 12, 60, 28);
    bus.retire_en = 1'b1;
    cycle();
    chk("sim_count", 32'(bus.count), 5);
    chk("sim_retired", 32'(bus.retire_valid), 1);
    chk("sim_tail", 32'(bus.alloc_idx), 6);
    drive_alloc(0, 0, 0, 0, 0);
    drive_cmpl(1, 12);
    cycle();
    chk("inv_cmpl_ret", 32'(bus.retire_valid), 0);
    chk("inv_cmpl_count", 32'(bus.count), 5);
    drive_cmpl(1, 1);
    cycle();
    chk("same_cycle_cmpl", 32'(bus.retire_valid), 0);
    drive_cmpl(0, 0);
    cycle();
    chk("cmpl_then_ret", 32'(bus.retire_valid), 1);

    // retire_en held low with a done head
    bus.retire_en = 1'b0;
    drive_cmpl(1, 2);
    cycle();
    drive_cmpl(0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_off", 32'(bus.retire_valid), 0);
    end
    bus.retire_en = 1'b1;
    cycle();
    chk("hold_release", 32'(bus.retire_valid), 1);
    chk("hold_freed", 32'(bus.freed_reg), 22);

    random_traffic(600, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/retire_unit.md
Name: retire_unit

Overview:
- In-order retirement buffer at the back end of the rename/free-pool loop.
- Rename dispatches one entry per cycle, carrying the new physical tag and the displaced old tag.
- Execution marks entries complete by index.
- Entries retire from the head in program order, at most one per cycle. Each retiring register-writing instruction returns one physical register to the free pool over the push_free_reg/freed_reg interface.

Parameters:
- DEPTH, 16, number of in-flight entries; power of two.
- PREG_WIDTH, 6, physical register tag width.
- AREG_WIDTH, 5, architectural register index width.
- IDX_WIDTH, $clog2(DEPTH), entry index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low (rst=0 resets at posedge clk).
- alloc_valid  in  1  rename presents an entry.
- alloc_ready  out  1  = !full.
- alloc_reg_write  in  1  entry writes a register.
- alloc_areg  in  AREG_WIDTH  architectural destination.
- alloc_preg  in  PREG_WIDTH  newly allocated physical tag.
- alloc_old_preg  in  PREG_WIDTH  previous mapping of alloc_areg.
- alloc_idx  out  IDX_WIDTH  combinational tail index; valid for the entry being accepted this cycle.
- cmpl_valid  in  1  completion strobe.
- cmpl_idx  in  IDX_WIDTH  entry completed.
- retire_en  in  1  retirement permitted this cycle.
- retire_valid  out  1  registered; an entry retired on the previous edge.
- retire_areg  out  AREG_WIDTH  registered.
- retire_preg  out  PREG_WIDTH  registered.
- push_free_reg  out  1  registered free-pool push.
- freed_reg  out  PREG_WIDTH  registered tag pushed to the free pool.
- count  out  IDX_WIDTH+1  occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Per-entry state: valid, done, reg_write, areg, preg, old_preg. Pointers head and tail are IDX_WIDTH bits and wrap modulo DEPTH.
- Reset (rst=0 at posedge):
  - head=tail=count=0; all valid/done cleared.
  - retire_valid, push_free_reg, retire_areg, retire_preg, freed_reg = 0.
  - empty=1, full=0.
  - Reset mid-operation discards all entries and emits no frees; the free pool has its own reset.
- Allocate:
  - Fires on alloc_valid && alloc_ready.
  - Writes the entry at tail with valid=1, done=0; tail+1.
  - alloc_valid while full: ignored, no state change.
- Complete:
  - cmpl_valid sets done[cmpl_idx] only if valid[cmpl_idx]=1; otherwise ignored.
  - Completing an already-done entry has no effect.
- Retire:
  - Condition at posedge: retire_en && valid[head] && done[head], evaluated on registered state.
  - On retire: clear valid/done at head; head+1.
  - Next cycle: retire_valid=1, retire_areg/retire_preg from the entry.
  - Next cycle: push_free_reg = entry.reg_write.
  - freed_reg = old_preg if areg!=0; freed_reg = preg if areg==0, because x0 is never remapped and its fresh tag must be recycled.
  - reg_write=0: retire_valid=1, push_free_reg=0, freed_reg=0.
  - Non-retire cycles drive all retire outputs to 0.
- Latency: completion at edge N lets the head retire at edge N+1. The free push is visible after edge N+1 and consumed by the free pool at edge N+2.
- Simultaneous events:
  - Alloc and retire in the same cycle: count unchanged, both pointers advance.
  - alloc_ready uses the pre-retire count, so no alloc is accepted when full even if the head retires that cycle.
  - Completion of the head in the same cycle as a retire decision does not retire that cycle.
- Width: count update is count + alloc_fire - retire_fire, never over/underflows given the guards.

Decomposition:
- constants.v gains ROB_DEPTH and shared PREG_WIDTH/AREG_WIDTH defaults. The same constants are used by the rename stage and this block.
- No sub-module: state arrays, pointers and retire registers stay in one module of roughly 150–200 lines.

Test Plan:
- Reset: hold rst=0 two cycles after arbitrary traffic -> count=0, empty=1, full=0, alloc_idx=0, all retire outputs 0.
- In-order retire:
  - Stimulus: alloc (rw=1, areg=3, preg=40, old=3) then (rw=1, areg=5, preg=41, old=5); complete idx1 then idx0; retire_en=1.
  - Required: no retire until idx0 done; then freed_reg=3 then freed_reg=5 on consecutive cycles, push_free_reg=1 each.
- x0 and no-write:
  - Alloc (rw=1, areg=0, preg=42, old=0) -> complete, retire -> freed_reg=42.
  - Alloc (rw=0) -> complete, retire -> retire_valid=1, push_free_reg=0.
- Full/wrap (DEPTH=16): 16 allocs -> full=1, alloc_ready=0, 17th alloc ignored. Complete all, retire all -> 16 pushes in order; head/tail wrap to 0; then 3 more allocs get alloc_idx=0,1,2.
- Simultaneous: count=5 with head done; alloc and retire in the same cycle -> count stays 5, head and tail both advance. Completion to an invalid index -> no change.
- retire_en=0 with head done for 3 cycles -> no outputs; retire_en=1 -> retire next edge.
